// File: rtl/ij_pkg.sv
// ij_pkg: constants and types shared by the inverse index walker and the
// forward index mux.
//   DIM     : grid dimension (5x5 lane grid)
//   LANES   : number of lanes in one walk
//   INV_OFF : inverse rotation offset (x -> x+3 mod 5)
//   FWD_OFF : forward rotation offset (x -> x+2 mod 5). The forward mux uses it,
//             so keeping it here keeps the forward and inverse maps in step.
//   state_t : IDLE/RUN/DONE encoding for the walker FSM
package ij_pkg;
    localparam int DIM     = 5;
    localparam int LANES   = DIM * DIM;
    localparam int INV_OFF = 3;
    localparam int FWD_OFF = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/ij_inv_map.sv
// ij_inv_map: combinational inverse rotation of one grid coordinate.
//   idx : destination coordinate (0..DIM-1 valid)
//   src : source coordinate, (idx + INV_OFF) mod DIM; codes >= DIM give 0
module ij_inv_map
    import ij_pkg::*;
#(
    parameter int SIZE = 3
) (
    input  logic [SIZE-1:0] idx,
    output logic [SIZE-1:0] src
);
    // One extra bit so idx+INV_OFF cannot overflow before the wrap compare.
    logic [SIZE:0] sum;

    always_comb begin
        sum = {1'b0, idx} + (SIZE+1)'(INV_OFF);
        if (idx >= SIZE'(DIM)) begin
            src = '0;
        end else if (sum >= (SIZE+1)'(DIM)) begin
            src = SIZE'(sum - (SIZE+1)'(DIM));
        end else begin
            src = sum[SIZE-1:0];
        end
    end
endmodule

// File: rtl/ij_inverse_walker.sv
// ij_inverse_walker: walks the 5x5 lane grid in row-major order (i fastest)
// and streams each destination coordinate with its inverse-rotated source
// coordinate.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : begin a 25-lane walk (only seen in IDLE)
//   abort     : synchronous cancel back to IDLE, no done
//   ready     : downstream accepts the current coordinate
//   valid     : a coordinate is on offer (high exactly in RUN)
//   i_out     : destination i
//   j_out     : destination j
//   src_i     : inverse-rotated i (combinational from i_out)
//   src_j     : inverse-rotated j (combinational from j_out)
//   lane_idx  : 5*j_out + i_out, kept as its own counter
//   busy      : high in RUN and DONE
//   done      : one-cycle pulse after the 25th transfer
//   fsm_state : current FSM state for debug/observation
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; while ready is low, valid and all coordinate outputs hold unchanged.
module ij_inverse_walker
    import ij_pkg::*;
#(
    parameter int SIZE  = 3,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             ready,
    output logic             valid,
    output logic [SIZE-1:0]  i_out,
    output logic [SIZE-1:0]  j_out,
    output logic [SIZE-1:0]  src_i,
    output logic [SIZE-1:0]  src_j,
    output logic [CNT_W-1:0] lane_idx,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fsm_state
);
    localparam logic [SIZE-1:0] MAX_IDX = SIZE'(DIM - 1);

    state_t state;
    logic   last_lane;

    // The final lane is the corner of the grid; wrap is an explicit compare.
    assign last_lane = (i_out == MAX_IDX) && (j_out == MAX_IDX);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            i_out    <= '0;
            j_out    <= '0;
            lane_idx <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // abort wins over a same-cycle handshake and over start
                state    <= S_IDLE;
                valid    <= 1'b0;
                busy     <= 1'b0;
                i_out    <= '0;
                j_out    <= '0;
                lane_idx <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_RUN;
                            valid    <= 1'b1;
                            busy     <= 1'b1;
                            i_out    <= '0;
                            j_out    <= '0;
                            lane_idx <= '0;
                        end
                    end
                    S_RUN: begin
                        if (ready) begin
                            if (last_lane) begin
                                state    <= S_DONE;
                                valid    <= 1'b0;
                                done     <= 1'b1;
                                i_out    <= '0;
                                j_out    <= '0;
                                lane_idx <= '0;
                            end else begin
                                lane_idx <= lane_idx + CNT_W'(1);
                                if (i_out == MAX_IDX) begin
                                    i_out <= '0;
                                    j_out <= j_out + SIZE'(1);
                                end else begin
                                    i_out <= i_out + SIZE'(1);
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        // start seen here is dropped, not queued
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    ij_inv_map #(.SIZE(SIZE)) u_inv_i (
        .idx (i_out),
        .src (src_i)
    );

    ij_inv_map #(.SIZE(SIZE)) u_inv_j (
        .idx (j_out),
        .src (src_j)
    );
endmodule

// File: tb/tb_ij_inverse_walker.sv
// Bench for ij_inverse_walker: full walks with and without backpressure,
// abort mid-walk, start pulses while busy, and async reset mid-walk.
module tb_ij_inverse_walker;
    localparam int SIZE  = 3;
    localparam int CNT_W = 5;
    localparam int W     = 4 * SIZE + CNT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             ready = 1'b0;
    logic             valid;
    logic [SIZE-1:0]  i_out, j_out, src_i, src_j;
    logic [CNT_W-1:0] lane_idx;
    logic             busy, done;
    logic [1:0]       fsm_state;

    ij_inverse_walker #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .ready     (ready),
        .valid     (valid),
        .i_out     (i_out),
        .j_out     (j_out),
        .src_i     (src_i),
        .src_j     (src_j),
        .lane_idx  (lane_idx),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int done_cnt = 0;
    int done_cycle = -1;
    int last_hs_cycle = -1;
    int start_cycle = 0;
    int inv_tab[5] = '{3, 4, 0, 1, 2};
    logic [W-1:0] prev_got = '0;
    bit prev_stall = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_pack(input int i, input int j);
        logic [SIZE-1:0]  ei, ej, si, sj;
        logic [CNT_W-1:0] el;
        ei = SIZE'(i);
        ej = SIZE'(j);
        si = SIZE'(inv_tab[i]);
        sj = SIZE'(inv_tab[j]);
        el = CNT_W'(5 * j + i);
        return {ei, ej, si, sj, el};
    endfunction

    logic [W-1:0] got_pack;
    assign got_pack = {i_out, j_out, src_i, src_j, lane_idx};

    // ---------------- monitor: pops on each handshake ----------------
    always @(negedge clk) begin
        if (rst && valid && ready && !abort) begin
            if (exp_q.size() == 0) begin
                check_eq("xfer_extra", 32'd1, 32'd0);
            end else begin
                check_eq("xfer", 32'(got_pack), 32'(exp_q.pop_front()));
            end
            last_hs_cycle = cycle + 1;
        end
        if (rst && prev_stall && valid) begin
            check_eq("hold", 32'(got_pack), 32'(prev_got));
        end
        prev_stall = rst && valid && !ready && !abort;
        prev_got   = got_pack;
        if (rst && done) begin
            done_cnt++;
            done_cycle = cycle;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle(input string tag);
        check_eq({tag, "_ctl"}, {29'd0, valid, busy, done}, 32'd0);
        check_eq({tag, "_coord"}, 32'(got_pack), 32'(exp_pack(0, 0)));
        check_eq({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
    endtask

    // bp: ready pattern 1,0,0,1; abort_at/rst_at: lane index at which to abort
    // or reset (-1 = never); extra_start: pulse start during RUN and DONE.
    task automatic walk(input bit bp, input int abort_at, input int rst_at, input bit extra_start);
        bit pat[4];
        int base_done;
        int k;
        bit ended;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        base_done = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        start_cycle = cycle + 1;
        for (int n = 0; n < 25; n++) exp_q.push_back(exp_pack(n % 5, n / 5));
        ended = 1'b0;
        k = 0;
        while (k < 200 && !ended) begin
            @(posedge clk); #1;
            start = extra_start && (k == 4 || done);
            ready = bp ? pat[k % 4] : 1'b1;
            abort = 1'b0;
            if (abort_at >= 0 && valid && lane_idx == CNT_W'(abort_at)) begin
                abort = 1'b1;
                ready = 1'b1;
                check_eq("abort_head", 32'(exp_q[0]), 32'(got_pack));
                @(posedge clk); #1;
                abort = 1'b0;
                check_idle("after_abort");
                check_eq("abort_left", exp_q.size(), 32'(25 - abort_at));
                repeat (5) @(posedge clk);
                #1;
                check_eq("abort_no_done", done_cnt, base_done);
                check_eq("abort_idle_valid", {31'd0, valid}, 32'd0);
                exp_q.delete();
                return;
            end
            if (rst_at >= 0 && valid && lane_idx == CNT_W'(rst_at)) begin
                #2 rst = 1'b0;
                #1 check_idle("async_rst");
                check_eq("rst_left", exp_q.size(), 32'(25 - rst_at));
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                check_eq("rst_no_done", done_cnt, base_done);
                exp_q.delete();
                return;
            end
            if (done) ended = 1'b1;
            k++;
        end
        if (!ended) check_eq("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("done_once", done_cnt - base_done, 32'd1);
        check_eq("q_empty", exp_q.size(), 32'd0);
        check_eq("done_after_last", done_cycle, last_hs_cycle);
        check_idle("post_walk");
        if (!bp) check_eq("done_latency", done_cycle - start_cycle, 32'd25);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle("in_reset");
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_idle("idle_no_start");

        walk(1'b0, -1, -1, 1'b0);          // full walk, ready high
        walk(1'b1, -1, -1, 1'b0);          // backpressure
        walk(1'b0, 12, -1, 1'b0);          // abort on a handshake at lane 12
        walk(1'b0, -1, -1, 1'b0);          // clean restart after abort
        walk(1'b0, -1, -1, 1'b1);          // start pulses during RUN and DONE
        walk(1'b0, -1, 7, 1'b0);           // async reset at lane 7
        walk(1'b1, -1, -1, 1'b0);          // clean walk after reset

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
